// File: rtl/detector_readout_averager_if.sv
// Sample stream from the detector ADC and the per-run result handshake toward the host.
// "master" is the ADC/host side; "slave" is the averager.
interface detector_readout_averager_if #(
    parameter int ADC_W = 12
);
    logic             smp_valid;
    logic [ADC_W-1:0] smp_data;
    logic             res_valid;
    logic             res_ready;
    logic [ADC_W-1:0] res_avg;
    logic [ADC_W-1:0] res_peak;
    logic             res_over;

    modport master (
        output smp_valid,
        output smp_data,
        output res_ready,
        input  res_valid,
        input  res_avg,
        input  res_peak,
        input  res_over
    );

    modport slave (
        input  smp_valid,
        input  smp_data,
        input  res_ready,
        output res_valid,
        output res_avg,
        output res_peak,
        output res_over
    );
endinterface

// File: rtl/detector_readout_averager.sv
// Per-run detector averager: discard settle samples, average a 2^LOG2_N window,
// report average/peak/threshold flag over a valid/ready handshake.
module detector_readout_averager #(
    parameter int ADC_W    = 12,
    parameter int LOG2_N   = 4,
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SETTLE_W-1:0] settle_cnt,
    input  logic [ADC_W-1:0]    threshold,
    output logic                busy,
    output logic                dropped,
    detector_readout_averager_if.slave bus
);

    localparam int SUM_W = ADC_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t              state_reg,   state_next;
    logic [SETTLE_W-1:0] settle_reg,  settle_next;
    logic [ADC_W-1:0]    thr_reg,     thr_next;
    logic [SUM_W-1:0]    sum_reg,     sum_next;
    logic [ADC_W-1:0]    peak_reg,    peak_next;
    logic [LOG2_N-1:0]   cnt_reg,     cnt_next;
    logic [ADC_W-1:0]    avg_reg,     avg_next;
    logic [ADC_W-1:0]    rpeak_reg,   rpeak_next;
    logic                over_reg,    over_next;
    logic                valid_reg,   valid_next;
    logic                dropped_reg, dropped_next;

    // Window arithmetic including the sample currently on the bus, so the
    // result can be registered on the same edge that takes the last sample.
    logic [SUM_W-1:0] sum_add;
    logic [ADC_W-1:0] smp_max;
    logic [ADC_W-1:0] avg_calc;

    always_comb begin
        sum_add  = sum_reg + SUM_W'(bus.smp_data);
        smp_max  = (bus.smp_data >= peak_reg) ? bus.smp_data : peak_reg;
        avg_calc = ADC_W'(sum_add >> LOG2_N);
    end

    always_comb begin
        state_next   = state_reg;
        settle_next  = settle_reg;
        thr_next     = thr_reg;
        sum_next     = sum_reg;
        peak_next    = peak_reg;
        cnt_next     = cnt_reg;
        avg_next     = avg_reg;
        rpeak_next   = rpeak_reg;
        over_next    = over_reg;
        valid_next   = valid_reg;
        dropped_next = dropped_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = SETTLE;
                    settle_next  = settle_cnt;
                    thr_next     = threshold;
                    dropped_next = 1'b0;
                    sum_next     = '0;
                    cnt_next     = '0;
                end
            end

            SETTLE: begin
                // A zero settle count still spends one cycle here and takes no sample.
                if (settle_reg == '0) begin
                    state_next = ACCUM;
                    peak_next  = '0;
                end else if (bus.smp_valid) begin
                    settle_next = settle_reg - 1'b1;
                    if (settle_reg == SETTLE_W'(1)) begin
                        state_next = ACCUM;
                        peak_next  = '0;
                    end
                end
            end

            ACCUM: begin
                if (bus.smp_valid) begin
                    sum_next  = sum_add;
                    peak_next = smp_max;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_IDX) begin
                        state_next = REPORT;
                        avg_next   = avg_calc;
                        rpeak_next = smp_max;
                        over_next  = (avg_calc >= thr_reg);
                        valid_next = 1'b1;
                    end
                end
            end

            REPORT: begin
                if (bus.smp_valid) begin
                    dropped_next = 1'b1;
                end
                if (valid_reg && bus.res_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            settle_reg  <= '0;
            thr_reg     <= '0;
            sum_reg     <= '0;
            peak_reg    <= '0;
            cnt_reg     <= '0;
            avg_reg     <= '0;
            rpeak_reg   <= '0;
            over_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            dropped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            settle_reg  <= settle_next;
            thr_reg     <= thr_next;
            sum_reg     <= sum_next;
            peak_reg    <= peak_next;
            cnt_reg     <= cnt_next;
            avg_reg     <= avg_next;
            rpeak_reg   <= rpeak_next;
            over_reg    <= over_next;
            valid_reg   <= valid_next;
            dropped_reg <= dropped_next;
        end
    end

    assign bus.res_valid = valid_reg;
    assign bus.res_avg   = avg_reg;
    assign bus.res_peak  = rpeak_reg;
    assign bus.res_over  = over_reg;
    assign busy          = (state_reg != IDLE);
    assign dropped       = dropped_reg;

endmodule

// File: tb/tb_detector_readout_averager.sv
// Randomised scoreboard bench for detector_readout_averager: stimulus pushes expected
// results from a window-arithmetic model, a negedge monitor pops them on each handshake.
module tb_detector_readout_averager;

    localparam int ADC_W    = 12;
    localparam int SETTLE_W = 8;
    localparam int N        = 16;

    typedef struct {
        logic [ADC_W-1:0] avg;
        logic [ADC_W-1:0] peak;
        logic             over;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [SETTLE_W-1:0] settle_cnt = '0;
    logic [ADC_W-1:0]    threshold = '0;
    logic                busy;
    logic                dropped;

    detector_readout_averager_if #(.ADC_W(ADC_W)) bus ();

    detector_readout_averager #(
        .ADC_W   (ADC_W),
        .LOG2_N  (4),
        .SETTLE_W(SETTLE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .settle_cnt(settle_cnt),
        .threshold (threshold),
        .busy      (busy),
        .dropped   (dropped),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];
    logic [ADC_W-1:0] stim[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the window is the N samples after the first 'settle' accepted samples.
    function automatic exp_t model(input int settle, input logic [ADC_W-1:0] thr);
        exp_t e;
        int sum = 0;
        int pk  = 0;
        for (int i = 0; i < N; i++) begin
            int v = int'(stim[settle + i]);
            sum += v;
            if (v > pk) pk = v;
        end
        e.avg  = ADC_W'(sum / N);
        e.peak = ADC_W'(pk);
        e.over = ((sum / N) >= int'(thr));
        return e;
    endfunction

    task automatic feed(input int first, input int count, input bit gaps, input bit noise);
        for (int i = first; i < first + count; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    bus.smp_data = ADC_W'($urandom);
                    start = noise && ($urandom_range(0, 2) == 0);
                    tick();
                    start = 1'b0;
                end
            end
            bus.smp_valid = 1'b1;
            bus.smp_data  = stim[i];
            start = noise && ($urandom_range(0, 2) == 0);
            tick();
            bus.smp_valid = 1'b0;
            bus.smp_data  = ADC_W'($urandom);
            start = 1'b0;
        end
    endtask

    task automatic do_run(input int settle, input logic [ADC_W-1:0] thr,
                          input bit gaps, input bit noise, input bit hold);
        exp_t e;
        e = model(settle, thr);
        sb.push_back(e);
        settle_cnt = SETTLE_W'(settle);
        threshold  = thr;
        start = 1'b1;
        tick();
        start = 1'b0;
        settle_cnt = SETTLE_W'($urandom);
        threshold  = ADC_W'($urandom);
        check("busy_after_start", busy, 1);
        check("dropped_cleared", dropped, 0);
        if (settle == 0) begin
            bus.smp_valid = 1'b1;
            bus.smp_data  = 12'hFFF;
            tick();
            bus.smp_valid = 1'b0;
        end
        if (hold) bus.res_ready = 1'b0;
        feed(0, settle + N, gaps, noise);
        check("latency_valid", bus.res_valid, 1);
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                if (c == 1 || c == 4 || c == 7) begin
                    bus.smp_valid = 1'b1;
                    bus.smp_data  = ADC_W'($urandom);
                end
                tick();
                bus.smp_valid = 1'b0;
                check("hold_valid", bus.res_valid, 1);
                check("hold_avg", bus.res_avg, e.avg);
                check("hold_peak", bus.res_peak, e.peak);
            end
            check("dropped_set", dropped, 1);
            bus.res_ready = 1'b1;
        end
        tick();
        check("idle_after_handshake", busy, 0);
        check("valid_low_after_handshake", bus.res_valid, 0);
        tick();
        check("avg_held_in_idle", bus.res_avg, e.avg);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_avg"}, bus.res_avg, 0);
        check({tag, "_res_peak"}, bus.res_peak, 0);
        check({tag, "_res_over"}, bus.res_over, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dropped"}, dropped, 0);
    endtask

    // Monitor: every completed handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] result avg=%0d peak=%0d over=%0b (expect %0d %0d %0b)",
                         bus.res_avg, bus.res_peak, bus.res_over, e.avg, e.peak, e.over);
                check("res_avg", bus.res_avg, e.avg);
                check("res_peak", bus.res_peak, e.peak);
                check("res_over", bus.res_over, e.over);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.smp_valid = 1'b0;
        bus.smp_data  = '0;
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        tick();

        // Abort a run eight samples into the window.
        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back(ADC_W'($urandom));
        settle_cnt = 8'd2;
        threshold  = 12'h010;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(0, 10, 1'b0, 1'b0);
        check("busy_mid_accum", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("midrun_reset");
        $display("[TB] run: mid-accum reset");

        stim.delete();
        repeat (3) stim.push_back(12'd100);
        repeat (N) stim.push_back(12'h200);
        do_run(3, 12'h100, 1'b0, 1'b0, 1'b0);
        $display("[TB] run: settle=3 flat 0x200");

        stim.delete();
        for (int i = 0; i < N; i++) stim.push_back(ADC_W'(i));
        do_run(0, 12'd8, 1'b0, 1'b0, 1'b0);
        $display("[TB] run: settle=0 ramp threshold=8");

        stim.delete();
        repeat (N) stim.push_back(12'hFFF);
        do_run(0, 12'hFFF, 1'b0, 1'b0, 1'b0);
        $display("[TB] run: full scale");

        stim.delete();
        for (int i = 0; i < 2 + N; i++) stim.push_back(ADC_W'($urandom));
        do_run(2, 12'h400, 1'b1, 1'b0, 1'b1);
        $display("[TB] run: held result with drops");

        // A sample in IDLE leaves the sticky flag alone.
        bus.smp_valid = 1'b1;
        bus.smp_data  = 12'h123;
        tick();
        bus.smp_valid = 1'b0;
        check("dropped_idle_sample", dropped, 1);
        check("busy_idle_sample", busy, 0);

        for (int r = 0; r < 12; r++) begin
            int settle = $urandom_range(0, 5);
            logic [ADC_W-1:0] thr;
            exp_t e0;
            stim.delete();
            for (int i = 0; i < settle + N; i++) stim.push_back(ADC_W'($urandom));
            e0 = model(settle, 12'd0);
            case ($urandom_range(0, 2))
                0: thr = e0.avg;
                1: thr = e0.avg + 12'd1;
                default: thr = ADC_W'($urandom);
            endcase
            do_run(settle, thr, 1'b0, 1'b0, 1'b0);
            do_run(settle, thr, 1'b1, 1'b1, 1'b0);
            $display("[TB] run: random pair %0d settle=%0d thr=%0d", r, settle, thr);
        end

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
